// File: rtl/pwm_capture_if.sv
// Slave-bus bundle for the PWM capture unit: address/data/strobes plus registered read data.
interface pwm_capture_if;
    logic [7:0]  address_i;
    logic [31:0] writedata_i;
    logic        write_i;
    logic [31:0] readdata_o;
    logic        read_i;
    logic        chipselect_i;

    modport master (
        output address_i, writedata_i, write_i, read_i, chipselect_i,
        input  readdata_o
    );

    modport slave (
        input  address_i, writedata_i, write_i, read_i, chipselect_i,
        output readdata_o
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM input-capture unit: measures high time and period of pwm_i in prescaled ticks.
// Optional glitch filter on the synchronized input is enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pwm_capture_if.slave bus,
    input  logic         pwm_i,
    output logic         irq_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_LOW  = 2'd3;

    localparam logic [7:0] A_CONTROL  = 8'h00;
    localparam logic [7:0] A_PRESCALE = 8'h04;
    localparam logic [7:0] A_HIGH     = 8'h08;
    localparam logic [7:0] A_PERIOD   = 8'h0C;
    localparam logic [7:0] A_STATUS   = 8'h10;

    logic [SYNC_STAGES-1:0] sync_q;
    logic        prev_q;
    logic        inv_lvl, lvl, rise, fall;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] div_q, div_d;
    logic [15:0] per_cnt_q, per_cnt_d;
    logic [15:0] hi_lat_q, hi_lat_d;
    logic [15:0] high_q, high_d;
    logic [15:0] period_q, period_d;
    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;
    logic [1:0]  state_q, state_d;
    logic [31:0] readdata_q, rdata;
    logic        irq_q;
    logic        en, tick, wr, rd, set_valid, set_ovf, clr_en;
    logic        unused_ok;

    assign wr = bus.chipselect_i & bus.write_i;
    assign rd = bus.chipselect_i & bus.read_i;
    assign en = ctrl_q[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

    assign inv_lvl = sync_q[SYNC_STAGES-1] ^ ctrl_q[1];

`ifdef PWM_CAP_FILTER_EN
    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_q;

    // A new level is accepted only once it has been seen FILTER_LEN cycles in a row.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_cnt_q <= '0;
            filt_q     <= 1'b0;
        end else if (inv_lvl == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_cnt_q <= '0;
            filt_q     <= inv_lvl;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    assign lvl       = filt_q;
    assign unused_ok = ^bus.writedata_i[31:16];
`else
    assign lvl       = inv_lvl;
    assign unused_ok = ^{bus.writedata_i[31:16], (FILTER_LEN == 0)};
`endif

    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;
    assign tick = en & (div_q == prescale_q);

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        hi_lat_d   = hi_lat_q;
        high_d     = high_q;
        period_d   = period_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        set_valid  = 1'b0;
        set_ovf    = 1'b0;
        clr_en     = 1'b0;
        div_d      = (!en || div_q == prescale_q) ? '0 : div_q + 16'd1;

        case (state_q)
            S_IDLE: if (en) state_d = S_ARM;
            S_ARM: begin
                if (rise) begin
                    state_d   = S_HIGH;
                    per_cnt_d = {15'd0, tick};
                end
            end
            S_HIGH: begin
                if (tick && per_cnt_q == 16'hFFFF) begin
                    set_ovf   = 1'b1;
                    per_cnt_d = '0;
                    state_d   = S_ARM;
                end else begin
                    per_cnt_d = per_cnt_q + {15'd0, tick};
                    if (fall) begin
                        hi_lat_d = per_cnt_q;
                        state_d  = S_LOW;
                    end
                end
            end
            default: begin
                if (tick && per_cnt_q == 16'hFFFF) begin
                    set_ovf   = 1'b1;
                    per_cnt_d = '0;
                    state_d   = S_ARM;
                end else if (rise) begin
                    high_d    = hi_lat_q;
                    period_d  = per_cnt_q;
                    set_valid = 1'b1;
                    if (ctrl_q[3]) begin
                        per_cnt_d = {15'd0, tick};
                        state_d   = S_HIGH;
                    end else begin
                        clr_en    = 1'b1;
                        per_cnt_d = '0;
                        state_d   = S_IDLE;
                    end
                end else begin
                    per_cnt_d = per_cnt_q + {15'd0, tick};
                end
            end
        endcase

        if (!en) begin
            state_d   = S_IDLE;
            per_cnt_d = '0;
            hi_lat_d  = '0;
        end

        // Ordering below gives CPU writes priority over the one-shot clear,
        // and hardware status sets priority over W1C.
        if (clr_en) ctrl_d[0] = 1'b0;
        if (wr && bus.address_i == A_CONTROL)  ctrl_d     = bus.writedata_i[3:0];
        if (wr && bus.address_i == A_PRESCALE) prescale_d = bus.writedata_i[15:0];
        if (wr && bus.address_i == A_STATUS) begin
            if (bus.writedata_i[0]) valid_d = 1'b0;
            if (bus.writedata_i[1]) ovf_d   = 1'b0;
        end
        if (set_valid) valid_d = 1'b1;
        if (set_ovf)   ovf_d   = 1'b1;
    end

    always_comb begin
        rdata = '0;
        case (bus.address_i)
            A_CONTROL:  rdata[3:0]  = ctrl_q;
            A_PRESCALE: rdata[15:0] = prescale_q;
            A_HIGH:     rdata[15:0] = high_q;
            A_PERIOD:   rdata[15:0] = period_q;
            A_STATUS:   rdata[2:0]  = {state_q != S_IDLE, ovf_q, valid_q};
            default:    rdata       = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q     <= 1'b0;
            ctrl_q     <= '0;
            prescale_q <= '0;
            div_q      <= '0;
            per_cnt_q  <= '0;
            hi_lat_q   <= '0;
            high_q     <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= S_IDLE;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= lvl;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            div_q      <= div_d;
            per_cnt_q  <= per_cnt_d;
            hi_lat_q   <= hi_lat_d;
            high_q     <= high_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            if (rd) readdata_q <= rdata;
            irq_q      <= ctrl_q[2] & (valid_q | ovf_q);
        end
    end

    assign bus.readdata_o = readdata_q;
    assign irq_o          = irq_q;
endmodule
